// File: rtl/ddr3_burst_writer.sv
// Streams 128-bit sample words into SDRAM through an Avalon-MM burst master.
// Words are buffered until a full burst is on hand, so avm_write never drops mid-burst.
module ddr3_burst_writer #(
  parameter int BURST_LEN  = 32,
  parameter int FIFO_DEPTH = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [25:0]  base_addr,
  input  logic [25:0]  total_words,
  input  logic [127:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [25:0]  avm_address,
  output logic         avm_write,
  output logic [127:0] avm_writedata,
  output logic [15:0]  avm_byteenable,
  output logic [8:0]   avm_burstcount,
  input  logic         avm_waitrequest,
  output logic         busy,
  output logic         done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LP_DEPTH = LW'(FIFO_DEPTH);
  localparam logic [25:0]   LP_BL26  = 26'(BURST_LEN);
  localparam logic [8:0]    LP_BL9   = 9'(BURST_LEN);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_BURST, S_DONE} state_t;

  state_t         r_state;
  logic [25:0]    r_addr;
  logic [25:0]    r_total;
  logic [25:0]    r_accepted;
  logic [25:0]    r_remaining;
  logic [8:0]     r_blen;
  logic [8:0]     r_beat;
  logic           r_avm_write;
  logic           r_busy;
  logic           r_done;
  logic [127:0]   r_writedata;

  logic [127:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [LW-1:0]  r_level;

  logic [8:0]     w_blen;
  logic           w_full;
  logic           w_push;
  logic           w_pop;
  logic           w_fill_go;
  logic           w_beat_ok;
  logic           w_last_beat;

  assign w_blen      = (r_remaining >= LP_BL26) ? LP_BL9 : r_remaining[8:0];
  assign w_full      = (r_level == LP_DEPTH);
  assign in_ready    = r_busy && !w_full && (r_accepted < r_total);
  assign w_push      = in_valid && in_ready;
  assign w_fill_go   = (r_state == S_FILL) && (32'(r_level) >= 32'(w_blen));
  assign w_beat_ok   = (r_state == S_BURST) && r_avm_write && !avm_waitrequest;
  assign w_last_beat = w_beat_ok && (r_beat == r_blen - 9'd1);
  // The first word is prefetched on burst entry; each accepted beat except the last fetches the next.
  assign w_pop       = w_fill_go || (w_beat_ok && !w_last_beat);

  assign avm_address    = r_addr;
  assign avm_write      = r_avm_write;
  assign avm_writedata  = r_writedata;
  assign avm_byteenable = 16'hFFFF;
  assign avm_burstcount = r_blen;
  assign busy           = r_busy;
  assign done           = r_done;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_total     <= '0;
      r_accepted  <= '0;
      r_remaining <= '0;
      r_blen      <= '0;
      r_beat      <= '0;
      r_avm_write <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_writedata <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      r_done <= 1'b0;

      if (w_push) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_accepted <= r_accepted + 26'd1;
      end
      if (w_pop) begin
        r_rd_ptr    <= r_rd_ptr + 1'b1;
        r_writedata <= r_mem[r_rd_ptr];
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + 1'b1;
      end else if (w_pop && !w_push) begin
        r_level <= r_level - 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr      <= base_addr;
            r_total     <= total_words;
            r_remaining <= total_words;
            r_accepted  <= '0;
            r_busy      <= 1'b1;
            r_state     <= (total_words == 26'd0) ? S_DONE : S_FILL;
          end
        end
        S_FILL: begin
          if (w_fill_go) begin
            r_blen      <= w_blen;
            r_beat      <= '0;
            r_avm_write <= 1'b1;
            r_state     <= S_BURST;
          end
        end
        S_BURST: begin
          if (w_last_beat) begin
            r_avm_write <= 1'b0;
            r_addr      <= r_addr + 26'(r_blen);
            r_remaining <= r_remaining - 26'(r_blen);
            r_state     <= (r_remaining == 26'(r_blen)) ? S_DONE : S_FILL;
          end else if (w_beat_ok) begin
            r_beat <= r_beat + 9'd1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_burst_writer.sv
// Scoreboard bench for ddr3_burst_writer: expected beats come from a burst-splitting
// model and are popped by a monitor on every accepted Avalon beat.
module tb_ddr3_burst_writer;

  localparam int BL    = 32;
  localparam int LIMIT = 4000;

  logic         clk;
  logic         reset;
  logic         start;
  logic [25:0]  base_addr;
  logic [25:0]  total_words;
  logic [127:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [25:0]  avm_address;
  logic         avm_write;
  logic [127:0] avm_writedata;
  logic [15:0]  avm_byteenable;
  logic [8:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic         busy;
  logic         done;

  ddr3_burst_writer #(.BURST_LEN(BL), .FIFO_DEPTH(64)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .total_words(total_words), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .avm_address(avm_address), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_waitrequest(avm_waitrequest),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [25:0]  addr;
    logic [8:0]   bc;
    logic [127:0] data;
  } beat_t;

  beat_t        exp_q[$];
  logic [127:0] cur_words[$];
  int           n_checks = 0;
  int           n_errors = 0;
  int           done_count = 0;
  int           write_seen = 0;
  bit           stall_en = 0;
  bit           abort = 0;
  bit           in_burst = 0;
  int           beat_i = 0;
  logic [25:0]  burst_addr;
  logic [8:0]   burst_bc;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    avm_waitrequest = 0;
    forever begin
      @(posedge clk);
      #1;
      avm_waitrequest = stall_en ? 1'($urandom % 2) : 1'b0;
    end
  end

  // Monitor: burst framing rules plus in-order comparison against the scoreboard.
  always @(negedge clk) begin
    beat_t e;
    if (reset) begin
      in_burst = 0;
      beat_i   = 0;
    end else begin
      if (done) begin
        done_count++;
        chk("busy_at_done", 128'(busy), 128'(0));
      end
      if (in_burst) chk("write_held", 128'(avm_write), 128'(1));
      if (avm_write) begin
        write_seen++;
        chk("byteenable", 128'(avm_byteenable), 128'(16'hFFFF));
        if (in_burst) begin
          chk("addr_stable", 128'(avm_address), 128'(burst_addr));
          chk("bc_stable", 128'(avm_burstcount), 128'(burst_bc));
        end else begin
          in_burst   = 1;
          burst_addr = avm_address;
          burst_bc   = avm_burstcount;
          beat_i     = 0;
        end
        if (!avm_waitrequest) begin
          chk("beat_expected", 128'(exp_q.size() != 0), 128'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_addr", 128'(avm_address), 128'(e.addr));
            chk("beat_bc", 128'(avm_burstcount), 128'(e.bc));
            chk("beat_data", avm_writedata, e.data);
          end
          beat_i++;
          if (beat_i == int'(burst_bc)) in_burst = 0;
        end
      end
    end
  end

  // Reference model: split the transfer into min(BL, remaining) bursts at base+offset mod 2^26.
  task automatic build_expected(input logic [25:0] base, input int total);
    int blen;
    cur_words.delete();
    for (int i = 0; i < total; i++) cur_words.push_back({$urandom, $urandom, $urandom, $urandom});
    for (int off = 0; off < total; off += BL) begin
      blen = (total - off < BL) ? (total - off) : BL;
      for (int k = 0; k < blen; k++) begin
        exp_q.push_back('{addr: 26'((32'(base) + 32'(off)) % 32'h4000000),
                          bc: 9'(blen), data: cur_words[off + k]});
      end
    end
  endtask

  task automatic pulse_start(input logic [25:0] base, input int total);
    @(posedge clk);
    #1;
    start = 1;
    base_addr = base;
    total_words = 26'(total);
    @(posedge clk);
    #1;
    start = 0;
    base_addr = 26'($urandom);
    total_words = 26'($urandom);
  endtask

  task automatic run_transfer(input logic [25:0] base, input int total, input bit stall,
                              input bit rand_valid, input bit spurious);
    int idx, cyc, d0;
    bit acc;
    $display("transfer base=0x%07h total=%0d stall=%0d", base, total, stall);
    build_expected(base, total);
    stall_en = stall;
    d0 = done_count;
    pulse_start(base, total);
    idx = 0;
    cyc = 0;
    while (idx < total && cyc < LIMIT) begin
      in_data  = cur_words[idx];
      in_valid = rand_valid ? ($urandom % 3 != 0) : 1'b1;
      start    = spurious && (cyc == 15);
      if (start) begin
        base_addr   = 26'($urandom);
        total_words = 26'($urandom_range(1, 50));
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) idx++;
    end
    in_valid = 0;
    start = 0;
    chk("words_accepted", 128'(idx), 128'(total));
    cyc = 0;
    while (done_count == d0 && cyc < LIMIT) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_once", 128'(done_count - d0), 128'(1));
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    stall_en = 0;
  endtask

  initial begin
    int w0;
    reset = 0;
    start = 0;
    base_addr = 0;
    total_words = 0;
    in_data = 0;
    in_valid = 0;
    #2;
    reset = 1;
    #1;
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_avm_write", 128'(avm_write), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_writedata", avm_writedata, 128'(0));
    repeat (3) @(posedge clk);
    #1;
    reset = 0;

    run_transfer(26'h0000100, 64, 0, 0, 0);
    run_transfer(26'h0002000, 40, 0, 1, 1);
    run_transfer(26'h0000040, 96, 1, 1, 0);
    run_transfer(26'h3FFFFF0, 32, 0, 0, 0);
    chk("wrapped_addr", 128'(avm_address), 128'(26'h0000010));
    run_transfer(26'h0000200, 40, 1, 1, 0);

    // Zero-length transfer: done two cycles after start, no bus activity.
    $display("transfer base=0x0000077 total=0");
    w0 = write_seen;
    @(posedge clk);
    #1;
    start = 1;
    base_addr = 26'h77;
    total_words = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    start = 0;
    @(negedge clk);
    chk("zero_done_c1", 128'(done), 128'(0));
    chk("zero_busy_c1", 128'(busy), 128'(1));
    @(negedge clk);
    chk("zero_done_c2", 128'(done), 128'(1));
    @(negedge clk);
    chk("zero_done_c3", 128'(done), 128'(0));
    repeat (3) @(posedge clk);
    chk("zero_no_write", 128'(write_seen - w0), 128'(0));

    for (int t = 0; t < 5; t++) begin
      run_transfer(26'($urandom), $urandom_range(1, 150), 1, 1, 0);
    end

    // Reset in the middle of a burst.
    $display("transfer base=0x0000300 total=64 reset_at_beat=10");
    build_expected(26'h0000300, 64);
    pulse_start(26'h0000300, 64);
    abort = 0;
    fork
      begin
        int idx, cyc;
        bit acc;
        idx = 0;
        cyc = 0;
        while (idx < 64 && !abort && cyc < LIMIT) begin
          in_data = cur_words[idx];
          in_valid = 1;
          @(negedge clk);
          acc = in_valid && in_ready;
          @(posedge clk);
          #1;
          cyc++;
          if (acc) idx++;
        end
      end
      begin
        int cyc;
        cyc = 0;
        while (!(in_burst && beat_i == 10) && cyc < LIMIT) begin
          @(posedge clk);
          #2;
          cyc++;
        end
        chk("reached_beat10", 128'(cyc < LIMIT), 128'(1));
        reset = 1;
        abort = 1;
        #1;
        chk("midrst_avm_write", 128'(avm_write), 128'(0));
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_in_ready", 128'(in_ready), 128'(0));
        chk("midrst_done", 128'(done), 128'(0));
        chk("midrst_writedata", avm_writedata, 128'(0));
        chk("midrst_address", 128'(avm_address), 128'(0));
      end
    join
    in_valid = 0;
    @(negedge clk);
    #1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 0;
    w0 = write_seen;
    repeat (6) @(posedge clk);
    #1;
    chk("post_rst_idle_busy", 128'(busy), 128'(0));
    chk("post_rst_no_write", 128'(write_seen - w0), 128'(0));
    run_transfer(26'h0000500, 32, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
